// File: rtl/vga_pkg.sv
// Shared types and widths for the VGA pixel feeder and its FIFO.
package vga_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ARM      = 2'd1,
        RUN      = 2'd2
    } state_e;

    localparam int PIX_W  = 8;
    localparam int WORD_W = PIX_W + 1;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead FIFO; head entry is read combinationally.
module pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the addresses match.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + (AW+1)'(1);
        if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule

// File: rtl/vga_pixel_feeder.sv
// Buffers a valid/ready pixel stream and feeds it to the VGA module,
// locked to the raster via start-of-frame marker and VSYNC.
//
// state    | meaning
// WAIT_SOF | discard words until an SOF word reaches the FIFO head
// ARM      | SOF at head, hold the FIFO until VSYNC is active
// RUN      | locked; one word consumed per displayed pixel
module vga_pixel_feeder
    import vga_pkg::*;
#(
    parameter int               H_ACTIVE   = 8,
    parameter int               V_ACTIVE   = 8,
    parameter int               DEPTH      = 16,
    parameter logic             VSYNC_POL  = 1'b0,
    parameter logic [PIX_W-1:0] FILL_COLOR = 8'h00
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             CE,
    input  logic             PIXEL_EN,
    input  logic             VSYNC,
    input  logic [PIX_W-1:0] IN_DATA,
    input  logic             IN_SOF,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [PIX_W-1:0] PIXEL,
    output logic             LOCKED,
    output logic             UNDERFLOW,
    output logic             SOF_ERR,
    input  logic             CLR_FLAGS
);
    localparam int                FRAME_PIX = H_ACTIVE * V_ACTIVE;
    localparam int                PCNT_W    = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(FRAME_PIX - 1);

    state_e            state_q, state_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              underflow_q, underflow_d;
    logic              sof_err_q, sof_err_d;
    logic              locked_q;
    logic              uf_set, se_set;

    logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [WORD_W-1:0] head;
    logic              head_sof;
    logic [PIX_W-1:0]  head_data;
    logic              disp_pop;

    assign fifo_push = IN_VALID && !fifo_full;

    pixel_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .push_i  (fifo_push),
        .wdata_i ({IN_SOF, IN_DATA}),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign {head_sof, head_data} = head;
    assign disp_pop = CE && PIXEL_EN;

    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        fifo_pop = 1'b0;
        uf_set   = 1'b0;
        se_set   = 1'b0;
        case (state_q)
            WAIT_SOF: begin
                if (!fifo_empty) begin
                    if (head_sof) state_d  = ARM;
                    else          fifo_pop = 1'b1;
                end
            end
            ARM: begin
                if (VSYNC == VSYNC_POL) begin
                    state_d = RUN;
                    pcnt_d  = '0;
                end
            end
            RUN: begin
                if (disp_pop) begin
                    if (fifo_empty) begin
                        uf_set  = 1'b1;
                        state_d = WAIT_SOF;
                    end else if ((pcnt_q == '0) && !head_sof) begin
                        se_set   = 1'b1;
                        fifo_pop = 1'b1;
                        state_d  = WAIT_SOF;
                    end else if ((pcnt_q != '0) && head_sof) begin
                        // Keep the early SOF word so it can start the next frame.
                        se_set  = 1'b1;
                        state_d = ARM;
                    end else begin
                        fifo_pop = 1'b1;
                        pcnt_d   = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + PCNT_W'(1);
                    end
                end
            end
            default: state_d = WAIT_SOF;
        endcase
        underflow_d = CLR_FLAGS ? 1'b0 : (underflow_q || uf_set);
        sof_err_d   = CLR_FLAGS ? 1'b0 : (sof_err_q || se_set);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= WAIT_SOF;
            pcnt_q      <= '0;
            underflow_q <= 1'b0;
            sof_err_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            underflow_q <= underflow_d;
            sof_err_q   <= sof_err_d;
            locked_q    <= (state_d == RUN);
        end
    end

    assign IN_READY  = !fifo_full;
    assign LOCKED    = locked_q;
    assign UNDERFLOW = underflow_q;
    assign SOF_ERR   = sof_err_q;
    assign PIXEL     = ((state_q == RUN) && !fifo_empty) ? head_data : FILL_COLOR;

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Directed bench for vga_pixel_feeder: frame table plus hand-written corner sequences.
module tb_vga_pixel_feeder;
    logic       CLK = 1'b0;
    logic       RESET_N, CE, PIXEL_EN, VSYNC, CLR_FLAGS;
    logic [7:0] IN_DATA;
    logic       IN_SOF, IN_VALID;
    logic       IN_READY, LOCKED, UNDERFLOW, SOF_ERR;
    logic [7:0] PIXEL;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] src_q[$];
    logic [8:0] dropped;
    logic       fire;

    typedef struct {
        logic       ce;
        logic       pen;
        logic [7:0] exp_pixel;
        logic       exp_ready;
    } vec_t;
    vec_t frame_vec[65];

    vga_pixel_feeder dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .CE        (CE),
        .PIXEL_EN  (PIXEL_EN),
        .VSYNC     (VSYNC),
        .IN_DATA   (IN_DATA),
        .IN_SOF    (IN_SOF),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .PIXEL     (PIXEL),
        .LOCKED    (LOCKED),
        .UNDERFLOW (UNDERFLOW),
        .SOF_ERR   (SOF_ERR),
        .CLR_FLAGS (CLR_FLAGS)
    );

    always #5 CLK = ~CLK;

    // Producer: presents the queue head, retires it once a handshake is seen.
    initial begin
        IN_VALID = 1'b0;
        IN_DATA  = 8'h00;
        IN_SOF   = 1'b0;
        forever begin
            @(negedge CLK);
            fire = IN_VALID && IN_READY && RESET_N;
            @(posedge CLK);
            #2;
            if (fire && src_q.size() > 0) dropped = src_q.pop_front();
            if (src_q.size() > 0) begin
                IN_VALID          = 1'b1;
                {IN_SOF, IN_DATA} = src_q[0];
            end else begin
                IN_VALID = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) cyc();
    endtask

    task automatic vsync_pulse();
        VSYNC = 1'b0;
        cyc();
        VSYNC = 1'b1;
    endtask

    task automatic pop_px(input string nm, input logic [7:0] exp);
        PIXEL_EN = 1'b1;
        @(negedge CLK);
        chk(nm, PIXEL, exp);
        cyc();
        PIXEL_EN = 1'b0;
    endtask

    initial begin
        // Entry 0 has CE low: no pop. Entries 1..64 display pixels 00..3F.
        frame_vec[0] = '{ce: 1'b0, pen: 1'b1, exp_pixel: 8'h00, exp_ready: 1'b0};
        for (int i = 1; i < 65; i++)
            frame_vec[i] = '{ce: 1'b1, pen: 1'b1, exp_pixel: 8'(i - 1), exp_ready: (i >= 2)};

        RESET_N   = 1'b0;
        CE        = 1'b0;
        PIXEL_EN  = 1'b0;
        VSYNC     = 1'b1;
        CLR_FLAGS = 1'b0;
        src_q.push_back({1'b0, 8'h55});
        wait_cyc(3);
        @(negedge CLK);
        chk("rst_in_valid_driven", IN_VALID, 1'b1);
        chk("rst_in_ready", IN_READY, 1'b1);
        chk("rst_pixel", PIXEL, 8'h00);
        chk("rst_locked", LOCKED, 1'b0);
        chk("rst_underflow", UNDERFLOW, 1'b0);
        chk("rst_sof_err", SOF_ERR, 1'b0);
        src_q.delete();
        wait_cyc(2);
        RESET_N = 1'b1;
        cyc();

        // Junk then a full SOF frame; CE held low while hunting for SOF.
        src_q.push_back({1'b0, 8'h11});
        src_q.push_back({1'b0, 8'h22});
        for (int i = 0; i < 64; i++) src_q.push_back({(i == 0), 8'(i)});
        wait_cyc(30);
        @(negedge CLK);
        chk("arm_not_locked", LOCKED, 1'b0);
        chk("arm_fifo_full", IN_READY, 1'b0);
        chk("arm_pixel_fill", PIXEL, 8'h00);
        cyc();
        CE = 1'b1;
        vsync_pulse();
        @(negedge CLK);
        chk("lock_after_vsync", LOCKED, 1'b1);
        chk("lock_head_pixel", PIXEL, 8'h00);
        cyc();

        for (int i = 0; i < 65; i++) begin
            CE       = frame_vec[i].ce;
            PIXEL_EN = frame_vec[i].pen;
            @(negedge CLK);
            chk("frame_pixel", PIXEL, frame_vec[i].exp_pixel);
            chk("frame_in_ready", IN_READY, frame_vec[i].exp_ready);
            chk("frame_locked", LOCKED, 1'b1);
            cyc();
        end
        CE       = 1'b1;
        PIXEL_EN = 1'b0;
        @(negedge CLK);
        chk("eof_pixel_fill", PIXEL, 8'h00);
        chk("eof_locked", LOCKED, 1'b1);
        chk("eof_no_underflow", UNDERFLOW, 1'b0);
        chk("eof_no_sof_err", SOF_ERR, 1'b0);
        cyc();

        // Second frame carries an early SOF at pixel 5, then 10 pixels and a stall.
        src_q.push_back({1'b1, 8'h40});
        for (int i = 1; i < 5; i++) src_q.push_back({1'b0, 8'(8'h40 + i)});
        src_q.push_back({1'b1, 8'h50});
        for (int i = 1; i < 10; i++) src_q.push_back({1'b0, 8'(8'h50 + i)});
        wait_cyc(20);
        for (int i = 0; i < 5; i++) pop_px("f2_pixel", 8'(8'h40 + i));
        @(negedge CLK);
        chk("f2_wrap_no_sof_err", SOF_ERR, 1'b0);
        cyc();
        pop_px("f2_early_sof_pixel", 8'h50);
        @(negedge CLK);
        chk("early_sof_err", SOF_ERR, 1'b1);
        chk("early_sof_unlocked", LOCKED, 1'b0);
        chk("early_sof_fill", PIXEL, 8'h00);
        cyc();
        wait_cyc(2);
        vsync_pulse();
        @(negedge CLK);
        chk("relock_locked", LOCKED, 1'b1);
        chk("relock_sof_pixel", PIXEL, 8'h50);
        cyc();
        for (int i = 0; i < 10; i++) pop_px("f3_pixel", 8'(8'h50 + i));
        pop_px("uf_pixel_fill", 8'h00);
        @(negedge CLK);
        chk("uf_flag", UNDERFLOW, 1'b1);
        chk("uf_unlocked", LOCKED, 1'b0);
        cyc();

        src_q.push_back({1'b1, 8'h70});
        src_q.push_back({1'b0, 8'h71});
        wait_cyc(5);
        vsync_pulse();
        @(negedge CLK);
        chk("uf_relock", LOCKED, 1'b1);
        chk("uf_relock_pixel", PIXEL, 8'h70);
        chk("uf_sticky", UNDERFLOW, 1'b1);
        chk("sof_err_sticky", SOF_ERR, 1'b1);
        cyc();
        pop_px("f4_pixel0", 8'h70);
        pop_px("f4_pixel1", 8'h71);

        // Underflow, clear and a push to the empty FIFO all on one edge.
        PIXEL_EN  = 1'b1;
        CLR_FLAGS = 1'b1;
        src_q.push_back({1'b1, 8'h99});
        cyc();
        PIXEL_EN  = 1'b0;
        CLR_FLAGS = 1'b0;
        @(negedge CLK);
        chk("clr_wins_underflow", UNDERFLOW, 1'b0);
        chk("clr_sof_err", SOF_ERR, 1'b0);
        chk("clr_uf_unlocked", LOCKED, 1'b0);
        cyc();
        wait_cyc(2);
        vsync_pulse();
        @(negedge CLK);
        chk("retained_push_locked", LOCKED, 1'b1);
        chk("retained_push_pixel", PIXEL, 8'h99);
        cyc();

        // Build up a mid-frame state with SOF_ERR set, then reset asynchronously.
        src_q.push_back({1'b0, 8'h9A});
        src_q.push_back({1'b1, 8'h9B});
        wait_cyc(3);
        pop_px("mf_pixel0", 8'h99);
        pop_px("mf_pixel1", 8'h9A);
        pop_px("mf_early_sof", 8'h9B);
        src_q.push_back({1'b1, 8'h9C});
        src_q.push_back({1'b0, 8'h9D});
        wait_cyc(3);
        vsync_pulse();
        pop_px("mf_relock_pixel", 8'h9B);
        @(negedge CLK);
        chk("mf_sof_err", SOF_ERR, 1'b1);
        chk("mf_head", PIXEL, 8'h9C);
        cyc();
        #2;
        RESET_N = 1'b0;
        #1;
        chk("async_rst_locked", LOCKED, 1'b0);
        chk("async_rst_ready", IN_READY, 1'b1);
        chk("async_rst_sof_err", SOF_ERR, 1'b0);
        chk("async_rst_underflow", UNDERFLOW, 1'b0);
        chk("async_rst_pixel", PIXEL, 8'h00);
        wait_cyc(2);
        RESET_N = 1'b1;
        cyc();
        src_q.push_back({1'b1, 8'hA0});
        wait_cyc(4);
        vsync_pulse();
        @(negedge CLK);
        chk("post_rst_locked", LOCKED, 1'b1);
        chk("post_rst_fifo_emptied", PIXEL, 8'hA0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_pixel_feeder.md
# vga_pixel_feeder

Upstream stage of the VGA output module: accepts a valid/ready pixel stream from the frame producer, buffers it in a small FIFO, and presents the current pixel on PIXEL to the VGA module, consuming one word per displayed pixel. It locks the incoming stream to the display raster using a start-of-frame marker and VSYNC. It reports underflow and framing errors through sticky flags.

## Interface
Parameters:
- H_ACTIVE, 8: visible pixels per line; must match the VGA module's horizontal display count.
- V_ACTIVE, 8: visible lines per frame.
- DEPTH, 16: FIFO depth in words; power of two, ≥ 2.
- VSYNC_POL, 1'b0: VSYNC level treated as "active".
- FILL_COLOR, 8'h00: colour driven whenever no valid pixel is available.

Ports:
- CLK  in  1  system clock; the single clock.
- RESET_N  in  1  asynchronous, active-low reset.
- CE  in  1  pixel clock enable; same strobe that drives the VGA module.
- PIXEL_EN  in  1  from the VGA module; high during visible pixels.
- VSYNC  in  1  from the VGA module.
- IN_DATA  in  8  producer pixel.
- IN_SOF  in  1  marks IN_DATA as the first pixel of a frame.
- IN_VALID  in  1  producer word valid.
- IN_READY  out  1  feeder can accept a word.
- PIXEL  out  8  pixel to the VGA module.
- LOCKED  out  1  high in RUN.
- UNDERFLOW  out  1  sticky; set on a display pop with an empty FIFO.
- SOF_ERR  out  1  sticky; set on a misplaced or missing SOF.
- CLR_FLAGS  in  1  synchronous clear of both sticky flags.

## Operation
- FIFO word is {sof, data}, 9 bits wide.
  - Push when IN_VALID && IN_READY.
  - IN_READY = !full.
  - Head is show-ahead (combinational read of the head entry).
- Display pop: CE && PIXEL_EN in RUN.
- Frame counter `pcnt`:
  - Width clog2(H_ACTIVE*V_ACTIVE).
  - Increments on each display pop.
  - Wraps to 0 after H_ACTIVE*V_ACTIVE−1.
- States:
  - WAIT_SOF:
    - Pop one word per clock (CE not required) while the head is non-SOF.
    - Head SOF → ARM.
  - ARM:
    - Hold the FIFO.
    - VSYNC == VSYNC_POL → RUN, with pcnt = 0.
  - RUN:
    - PIXEL = head data.
    - On a display pop, the first matching rule applies:
      1. FIFO empty: UNDERFLOW set, PIXEL = FILL_COLOR for that cycle, → WAIT_SOF.
      2. pcnt == 0 and head sof == 0: SOF_ERR set, → WAIT_SOF; the word is discarded.
      3. pcnt != 0 and head sof == 1: SOF_ERR set, no pop, → ARM.
      4. Otherwise: pop the word and increment pcnt.
- PIXEL = FILL_COLOR in every state other than RUN, and in RUN whenever the FIFO is empty.
- CLR_FLAGS has priority over setting a flag in the same cycle, i.e. the flag ends cleared.

## Timing
- Reset values:
  - State WAIT_SOF, FIFO empty, pcnt 0.
  - IN_READY 1, LOCKED 0, UNDERFLOW 0, SOF_ERR 0, PIXEL FILL_COLOR.
- Input to head latency: a pushed word is visible at the head one clock after the push edge.
- PIXEL is combinational from head/state; it changes on the clock edge that performs a pop.
- The VGA module samples the current pixel for the whole PIXEL_EN period; the pop occurs on the CE edge that ends it.
- Simultaneous push and pop:
  - Allowed, including when the FIFO is full (IN_READY is 0, so no push).
  - When empty, a push and the RUN pop rule in the same cycle resolve as underflow; the pushed word is retained.
- State transitions take effect on the next clock edge.
- Reset assertion mid-frame empties the FIFO immediately, asynchronously.

## Structure
- Package vga_pkg:
  - state enum {WAIT_SOF, ARM, RUN}.
  - Pixel width constant (8).
  - FIFO word width (9).
- Sub-module pixel_fifo:
  - Parameterised DEPTH/WIDTH, synchronous, show-ahead.
  - Pointers one bit wider than the address for full/empty.
  - Async active-low reset.
- Top level holds the FSM, pcnt and flags.

## Test plan
- Reset with IN_VALID = 1 → IN_READY = 1, PIXEL = 8'h00, LOCKED = 0, no pops until an SOF word arrives.
- Push junk 8'h11, 8'h22 then an SOF frame 8'h00..8'h3F → the junk is discarded in WAIT_SOF; LOCKED rises after VSYNC; PIXEL follows 00,01,…,3F over 64 PIXEL_EN periods; pcnt wraps.
- Stall the producer after 10 pixels of a frame → UNDERFLOW = 1, PIXEL = FILL_COLOR, state WAIT_SOF; the next SOF relocks after VSYNC.
- Second frame with SOF on pixel 5 → SOF_ERR = 1 at pcnt 5; state ARM; relock on the next VSYNC with PIXEL = the SOF word.
- Fill the FIFO to 16 words with PIXEL_EN low → IN_READY = 0; one CE && PIXEL_EN pop → IN_READY = 1 the same cycle after the pop edge.
- Assert RESET_N low mid-frame → immediate empty FIFO, LOCKED = 0, flags 0; CLR_FLAGS concurrent with underflow leaves UNDERFLOW = 0.
